acia_bus_scheduler: RTL

Sequences all accesses to the external 6551 ACIA and shares its register bus between the CoCo host decode path and an autonomous receive poller. The poller reads ACIA status at a fixed interval and drains received bytes into a local FIFO, so host data reads never miss bytes between CPU polls. The block sits between the $FF68-$FF6F/$FF78-$FF7F decode logic and the ACIA pins.

---
 rtl/acia_ctl_pkg.sv | 27 ++
 rtl/acia_rx_fifo.sv | 51 +++++
 rtl/acia_bus_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/acia_ctl_pkg.sv
// acia_ctl_pkg: ACIA register map, status bit positions and scheduler states
package acia_ctl_pkg;
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CMD  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int ST_OVRN = 2;
    localparam int ST_RDRF = 3;
    localparam int ST_IRQ  = 7;

    typedef enum logic [1:0] {IDLE, HOST_BUS, POLL_STAT, POLL_DATA} state_t;

    // Writes and command/control reads must go to the chip; data/status reads are local.
    function automatic logic is_bus_access(input logic rw, input logic [1:0] addr);
        is_bus_access = !rw || addr == REG_CMD || addr == REG_CTRL;
    endfunction

    // Host-visible status: FIFO state replaces RDRF/IRQ, sticky FIFO overrun folds into OVRN.
    function automatic logic [7:0] make_status(input logic [7:0] polled, input logic not_empty,
                                               input logic ovr);
        make_status          = polled;
        make_status[ST_RDRF] = not_empty;
        make_status[ST_OVRN] = ovr || polled[ST_OVRN];
        make_status[ST_IRQ]  = not_empty;
    endfunction
endpackage

// File: rtl/acia_rx_fifo.sv
// acia_rx_fifo: receive byte FIFO with wrap-bit pointers and concurrent push/pop
module acia_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance; a flush collapses both pointers to empty.
    always_comb begin
        wr_d = clear_i ? '0 : wr_q + {{AW{1'b0}}, do_push};
        rd_d = clear_i ? '0 : rd_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is write-only on push; the head is read combinationally so a pop returns it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/acia_bus_scheduler.sv
// acia_bus_scheduler: arbitrates the 6551 bus between host accesses and the receive poller
module acia_bus_scheduler
    import acia_ctl_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int POLL_DIV    = 64,
    parameter int ACIA_CYCLES = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        host_req_i,
    input  logic                        host_rw_i,
    input  logic [1:0]                  host_addr_i,
    input  logic [7:0]                  host_wdata_i,
    output logic [7:0]                  host_rdata_o,
    output logic                        host_ack_o,
    output logic                        acia_ce_o,
    output logic                        acia_rw_o,
    output logic [1:0]                  acia_rs_o,
    output logic [7:0]                  acia_wdata_o,
    input  logic [7:0]                  acia_rdata_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        overrun_o,
    output logic                        irq_o
);
    localparam int TW = $clog2(POLL_DIV);
    localparam int CW = $clog2(ACIA_CYCLES + 1);
    localparam logic [TW-1:0] T_RELOAD = TW'(POLL_DIV - 1);
    localparam logic [CW-1:0] C_LAST   = CW'(ACIA_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP    = CW'(ACIA_CYCLES);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pend_q, pend_d;
    logic [1:0]    rs_q, rs_d;
    logic          rw_q, rw_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    stat_q, stat_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    last_q, last_d;
    logic          ack_q, ack_d;
    logic          ovr_q, ovr_d;

    logic          req_live, bus_req, loc_req, loc_data, loc_stat;
    logic          last_ce, bus_done, enter_poll, push, flush;
    logic          full, empty;
    logic [7:0]    head;

    // The request is still held during its own ack cycle, so it is ignored then.
    assign req_live   = host_req_i && !ack_q;
    assign bus_req    = req_live && is_bus_access(host_rw_i, host_addr_i);
    assign loc_req    = req_live && !is_bus_access(host_rw_i, host_addr_i);
    assign loc_data   = loc_req && host_addr_i == REG_DATA;
    assign loc_stat   = loc_req && host_addr_i == REG_STAT;
    assign last_ce    = state_q != IDLE && cnt_q == C_LAST;
    assign bus_done   = state_q == HOST_BUS && last_ce;
    assign enter_poll = state_q == IDLE && !bus_req && pend_q;
    assign push       = state_q == POLL_DATA && last_ce && !full;
    assign flush      = bus_done && !rw_q && rs_q == REG_STAT;

    assign acia_ce_o    = state_q != IDLE && cnt_q < C_GAP;
    assign acia_rw_o    = rw_q;
    assign acia_rs_o    = rs_q;
    assign acia_wdata_o = wdata_q;
    assign host_rdata_o = rdata_q;
    assign host_ack_o   = ack_q;
    assign overrun_o    = ovr_q;
    assign irq_o        = !empty;

    acia_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (flush),
        .push_i  (push),
        .pop_i   (loc_data),
        .wdata_i (acia_rdata_i),
        .rdata_o (head),
        .count_o (fifo_count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // Bus sequencer: each access holds ce for ACIA_CYCLES; the status poll keeps one
    // extra ce-low cycle so a following data read is separated from it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        rs_d    = rs_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        stat_d  = stat_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus_req) begin
                    state_d = HOST_BUS;
                    rs_d    = host_addr_i;
                    rw_d    = host_rw_i;
                    wdata_d = host_wdata_i;
                end else if (pend_q) begin
                    state_d = POLL_STAT;
                    rs_d    = REG_STAT;
                    rw_d    = 1'b1;
                end
            end
            HOST_BUS: begin
                state_d = last_ce ? IDLE : state_q;
                stat_d  = flush ? 8'h00 : stat_q;
            end
            POLL_STAT: begin
                stat_d = last_ce ? acia_rdata_i : stat_q;
                if (cnt_q == C_GAP) begin
                    state_d = stat_q[ST_RDRF] ? POLL_DATA : IDLE;
                    cnt_d   = '0;
                    rs_d    = REG_DATA;
                end
            end
            POLL_DATA: state_d = last_ce ? IDLE : state_q;
            default:   state_d = IDLE;
        endcase
    end

    // Poll timer, host responses, last-dequeued byte and sticky overrun.
    always_comb begin
        timer_d = timer_q == '0 ? T_RELOAD : timer_q - 1'b1;
        pend_d  = timer_q == '0 || (pend_q && !enter_poll);
        ack_d   = loc_req || bus_done;
        rdata_d = loc_stat ? make_status(stat_q, !empty, ovr_q) :
                  loc_data ? (empty ? last_q : head) :
                  (bus_done && rw_q) ? acia_rdata_i : rdata_q;
        last_d  = (loc_data && !empty) ? head : last_q;
        ovr_d   = (state_q == POLL_DATA && last_ce && full) ? 1'b1 :
                  (loc_stat || flush) ? 1'b0 : ovr_q;
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            timer_q <= T_RELOAD;
            pend_q  <= 1'b0;
            rs_q    <= REG_DATA;
            rw_q    <= 1'b1;
            wdata_q <= 8'h00;
            stat_q  <= 8'h00;
            rdata_q <= 8'h00;
            last_q  <= 8'h00;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            stat_q  <= stat_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule
